// File: rtl/carry_cfg_pkg.sv
//------------------------------------------------------------------------------
// Module   : carry_cfg_pkg
// Purpose  : Shared constants and FSM encoding for the carry-chain config loader.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package carry_cfg_pkg;

  localparam int CFG_BITS_PER_SLICE = 5;
  localparam int CY0_LSB            = 0;
  localparam int CY0_W              = 3;
  localparam int CYO_BIT            = 3;
  localparam int BYP_BIT            = 4;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SHIFT  = 2'd1,
    ST_CHECK  = 2'd2,
    ST_COMMIT = 2'd3
  } cfg_state_e;

  // Number of data bits in a frame, excluding the trailing parity bit.
  function automatic int frame_data_bits(input int n_slices);
    return n_slices * CFG_BITS_PER_SLICE;
  endfunction

endpackage

`default_nettype wire

// File: rtl/carry_cfg_shadow.sv
//------------------------------------------------------------------------------
// Module   : carry_cfg_shadow
// Purpose  : Clearable shadow register written one bit at a time by index.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module carry_cfg_shadow #(
  parameter int TOTAL_BITS = 20,
  parameter int IDX_W      = $clog2(TOTAL_BITS + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_clr,
  input  logic                  i_wr_en,
  input  logic [IDX_W-1:0]      i_wr_idx,
  input  logic                  i_wr_bit,
  output logic [TOTAL_BITS-1:0] o_shadow
);

  logic [TOTAL_BITS-1:0] r_shadow;
  logic [TOTAL_BITS-1:0] w_hit;

  // One-hot decode of the write index; indices past TOTAL_BITS-1 hit nothing.
  for (genvar i = 0; i < TOTAL_BITS; i++) begin : g_dec
    assign w_hit[i] = i_wr_en && (i_wr_idx == IDX_W'(i));
  end

  always_ff @(posedge clk) begin
    if (rst || i_clr) begin
      r_shadow <= '0;
    end else begin
      r_shadow <= (r_shadow & ~w_hit) | ({TOTAL_BITS{i_wr_bit}} & w_hit);
    end
  end

  assign o_shadow = r_shadow;

endmodule

`default_nettype wire

// File: rtl/carry_cfg_loader.sv
//------------------------------------------------------------------------------
// Module   : carry_cfg_loader
// Purpose  : Serial, parity-checked loader for per-slice carry-chain selects.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module carry_cfg_loader
  import carry_cfg_pkg::*;
#(
  parameter int N_SLICES = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  cfg_start,
  input  logic                  cfg_valid,
  input  logic                  cfg_data,
  output logic                  cfg_ready,
  output logic [3*N_SLICES-1:0] cy0_sel_bus,
  output logic [N_SLICES-1:0]   cyo_sel_bus,
  output logic [N_SLICES-1:0]   bypass_bus,
  output logic                  busy,
  output logic                  cfg_done,
  output logic                  cfg_err
);

  localparam int c_frame_bits = frame_data_bits(N_SLICES);
  localparam int c_cnt_w      = $clog2(c_frame_bits + 1);
  localparam logic [c_cnt_w-1:0] c_last_idx = c_cnt_w'(c_frame_bits - 1);

  cfg_state_e r_state;
  cfg_state_e w_state_next;

  logic [c_cnt_w-1:0]      r_cnt;
  logic                    r_parity;
  logic                    r_ready;
  logic                    r_busy;
  logic                    r_done;
  logic                    r_err;
  logic [3*N_SLICES-1:0]   r_cy0;
  logic [N_SLICES-1:0]     r_cyo;
  logic [N_SLICES-1:0]     r_byp;

  logic                    w_beat;
  logic                    w_clear;
  logic                    w_shift_wr;
  logic                    w_err_set;
  logic [c_frame_bits-1:0] w_shadow;
  logic [3*N_SLICES-1:0]   w_cy0;
  logic [N_SLICES-1:0]     w_cyo;
  logic [N_SLICES-1:0]     w_byp;

  // r_ready mirrors "state is SHIFT or CHECK", so it doubles as the beat qualifier.
  assign w_beat = cfg_valid && r_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_clear      = 1'b0;
    w_shift_wr   = 1'b0;
    w_err_set    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (cfg_start) begin
          w_clear      = 1'b1;
          w_state_next = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (cfg_start) begin
          w_clear      = 1'b1;
          w_state_next = ST_SHIFT;
        end else if (w_beat) begin
          w_shift_wr = 1'b1;
          if (r_cnt == c_last_idx) begin
            w_state_next = ST_CHECK;
          end
        end
      end
      ST_CHECK: begin
        if (cfg_start) begin
          w_clear      = 1'b1;
          w_state_next = ST_SHIFT;
        end else if (w_beat) begin
          if (r_parity ^ cfg_data) begin
            w_err_set    = 1'b1;
            w_state_next = ST_IDLE;
          end else begin
            w_state_next = ST_COMMIT;
          end
        end
      end
      ST_COMMIT: begin
        w_state_next = ST_IDLE;
      end
      default: begin
        w_state_next = ST_IDLE;
      end
    endcase
  end

  carry_cfg_shadow #(
    .TOTAL_BITS (c_frame_bits),
    .IDX_W      (c_cnt_w)
  ) u_shadow (
    .clk      (clk),
    .rst      (reset),
    .i_clr    (w_clear),
    .i_wr_en  (w_shift_wr),
    .i_wr_idx (r_cnt),
    .i_wr_bit (cfg_data),
    .o_shadow (w_shadow)
  );

  for (genvar s = 0; s < N_SLICES; s++) begin : g_slice
    localparam int c_base = s * CFG_BITS_PER_SLICE;
    assign w_cy0[CY0_W*s +: CY0_W] = w_shadow[c_base + CY0_LSB +: CY0_W];
    assign w_cyo[s]                = w_shadow[c_base + CYO_BIT];
    assign w_byp[s]                = w_shadow[c_base + BYP_BIT];
  end

  // Status flags are registered from the next state so every output is a flop.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt    <= '0;
      r_parity <= 1'b0;
      r_ready  <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_err    <= 1'b0;
      r_cy0    <= '0;
      r_cyo    <= '0;
      r_byp    <= '0;
    end else begin
      r_ready <= (w_state_next == ST_SHIFT) || (w_state_next == ST_CHECK);
      r_busy  <= (w_state_next != ST_IDLE);
      r_done  <= (w_state_next == ST_COMMIT);

      if (w_clear) begin
        r_cnt    <= '0;
        r_parity <= 1'b0;
        r_err    <= 1'b0;
      end else if (w_shift_wr) begin
        r_cnt    <= r_cnt + c_cnt_w'(1);
        r_parity <= r_parity ^ cfg_data;
      end

      if (w_err_set) begin
        r_err <= 1'b1;
      end

      if (w_state_next == ST_COMMIT) begin
        r_cy0 <= w_cy0;
        r_cyo <= w_cyo;
        r_byp <= w_byp;
      end
    end
  end

  assign cfg_ready   = r_ready;
  assign busy        = r_busy;
  assign cfg_done    = r_done;
  assign cfg_err     = r_err;
  assign cy0_sel_bus = r_cy0;
  assign cyo_sel_bus = r_cyo;
  assign bypass_bus  = r_byp;

endmodule

`default_nettype wire

// File: tb/tb_carry_cfg_loader.sv
//------------------------------------------------------------------------------
// Module   : tb_carry_cfg_loader
// Purpose  : Scoreboard bench for the carry-chain configuration loader.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_carry_cfg_loader;

  localparam int N  = 4;
  localparam int FB = 5 * N + 1;

  localparam logic [FB-1:0] c_good  = {1'b0, {N{5'b01101}}};
  localparam logic [FB-1:0] c_ones  = {FB{1'b1}};
  localparam logic [FB-1:0] c_abort = 21'h180000;

  logic           clk       = 1'b0;
  logic           reset     = 1'b1;
  logic           cfg_start = 1'b0;
  logic           cfg_valid = 1'b0;
  logic           cfg_data  = 1'b0;
  logic           cfg_ready;
  logic [3*N-1:0] cy0_sel_bus;
  logic [N-1:0]   cyo_sel_bus;
  logic [N-1:0]   bypass_bus;
  logic           busy;
  logic           cfg_done;
  logic           cfg_err;

  typedef struct {
    logic           err;
    logic [3*N-1:0] cy0;
    logic [N-1:0]   cyo;
    logic [N-1:0]   byp;
  } exp_t;

  exp_t           sb[$];
  logic [3*N-1:0] m_cy0 = '0;
  logic [N-1:0]   m_cyo = '0;
  logic [N-1:0]   m_byp = '0;

  int   n_total   = 0;
  int   n_bad     = 0;
  int   cyc       = 0;
  int   par_cyc   = 0;
  logic prev_err  = 1'b0;
  bit   done_seen = 1'b0;

  carry_cfg_loader #(.N_SLICES(N)) dut (
    .clk         (clk),
    .reset       (reset),
    .cfg_start   (cfg_start),
    .cfg_valid   (cfg_valid),
    .cfg_data    (cfg_data),
    .cfg_ready   (cfg_ready),
    .cy0_sel_bus (cy0_sel_bus),
    .cyo_sel_bus (cyo_sel_bus),
    .bypass_bus  (bypass_bus),
    .busy        (busy),
    .cfg_done    (cfg_done),
    .cfg_err     (cfg_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_total++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s got=%0h want=%0h (t=%0t)", tag, got, want, $time);
    end
  endtask

  // Expected outcome of a frame, derived from its bit order and parity.
  task automatic push_expect(input logic [FB-1:0] fr);
    exp_t e;
    if (^fr) begin
      e.err = 1'b1;
    end else begin
      e.err = 1'b0;
      for (int s = 0; s < N; s++) begin
        for (int b = 0; b < 3; b++) m_cy0[3*s+b] = fr[5*s+b];
        m_cyo[s] = fr[5*s+3];
        m_byp[s] = fr[5*s+4];
      end
    end
    e.cy0 = m_cy0;
    e.cyo = m_cyo;
    e.byp = m_byp;
    sb.push_back(e);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (done_seen) begin
      check_value("done_pulse_end", {30'd0, cfg_done, busy}, 32'd0);
      done_seen = 1'b0;
    end
    if (cfg_done || (cfg_err && !prev_err)) begin
      if (sb.size() == 0) begin
        check_value("sb_unexpected", sb.size(), 1);
      end else begin
        e = sb.pop_front();
        check_value("sb_err",     cfg_err,      e.err);
        check_value("sb_done",    cfg_done,     !e.err);
        check_value("sb_cy0",     cy0_sel_bus,  e.cy0);
        check_value("sb_cyo",     cyo_sel_bus,  e.cyo);
        check_value("sb_byp",     bypass_bus,   e.byp);
        check_value("sb_latency", cyc - par_cyc, 1);
        if (e.err) check_value("err_busy", busy, 1'b0);
      end
      if (cfg_done) done_seen = 1'b1;
    end
    prev_err = cfg_err;
  end

  task automatic pulse_start(input logic hot);
    @(negedge clk);
    cfg_start = 1'b1;
    cfg_valid = hot;
    cfg_data  = 1'b1;
    @(negedge clk);
    cfg_start = 1'b0;
    cfg_valid = 1'b0;
    check_value("start_busy",  busy,      1'b1);
    check_value("start_ready", cfg_ready, 1'b1);
  endtask

  task automatic send_bit(input logic b, input int gap);
    int n;
    repeat (gap) begin
      @(negedge clk);
      cfg_valid = 1'b0;
      cfg_data  = 1'($urandom_range(0, 1));
    end
    @(negedge clk);
    cfg_valid = 1'b1;
    cfg_data  = b;
    n = 0;
    while (!cfg_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!cfg_ready) check_value("ready_wait", cfg_ready, 1'b1);
    par_cyc = cyc;
  endtask

  task automatic wait_sb();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 10) begin
      @(negedge clk);
      #1;
      n++;
    end
    check_value("sb_drain", sb.size(), 0);
  endtask

  task automatic send_bits(input logic [FB-1:0] fr, input bit stall);
    push_expect(fr);
    for (int k = 0; k < FB; k++) send_bit(fr[k], stall ? int'($urandom_range(0, 5)) : 0);
    @(negedge clk);
    cfg_valid = 1'b0;
    wait_sb();
  endtask

  task automatic check_buses(input string tag, input logic [3*N-1:0] cy0,
                             input logic [N-1:0] cyo, input logic [N-1:0] byp, input logic err);
    check_value({tag, "_cy0"}, cy0_sel_bus, cy0);
    check_value({tag, "_cyo"}, cyo_sel_bus, cyo);
    check_value({tag, "_byp"}, bypass_bus,  byp);
    check_value({tag, "_err"}, cfg_err,     err);
  endtask

  task automatic check_reset_outputs(input string tag);
    check_buses(tag, '0, '0, '0, 1'b0);
    check_value({tag, "_ready"}, cfg_ready, 1'b0);
    check_value({tag, "_busy"},  busy,      1'b0);
    check_value({tag, "_done"},  cfg_done,  1'b0);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check_reset_outputs("rst");
    reset = 1'b0;

    // Good frame: every slice CY0=101, CYO=1, bypass=0.
    pulse_start(1'b0);
    send_bits(c_good, 1'b0);
    check_buses("good", 12'hB6D, 4'hF, 4'h0, 1'b0);
    check_value("good_idle", busy, 1'b0);

    // Odd parity frame must be rejected with buses left alone.
    pulse_start(1'b0);
    send_bits(c_ones, 1'b0);
    check_buses("bad", 12'hB6D, 4'hF, 4'h0, 1'b1);

    // Same good frame with random valid gaps; start also clears the sticky error.
    pulse_start(1'b0);
    check_value("stall_errclr", cfg_err, 1'b0);
    send_bits(c_good, 1'b1);
    check_buses("stall", 12'hB6D, 4'hF, 4'h0, 1'b0);

    // Abort after 7 beats; a bit presented with the restart is dropped.
    pulse_start(1'b0);
    for (int k = 0; k < 7; k++) send_bit(1'b1, 0);
    pulse_start(1'b1);
    check_value("abort_err", cfg_err, 1'b0);
    check_buses("abort_hold", 12'hB6D, 4'hF, 4'h0, 1'b0);
    send_bits(c_abort, 1'b0);
    check_buses("abort", 12'h000, 4'h0, 4'h8, 1'b0);

    // Reset in the middle of a frame.
    pulse_start(1'b0);
    for (int k = 0; k < 12; k++) send_bit(c_good[k], 0);
    @(negedge clk);
    reset     = 1'b1;
    cfg_valid = 1'b0;
    @(negedge clk);
    check_reset_outputs("midrst");
    reset = 1'b0;
    m_cy0 = '0;
    m_cyo = '0;
    m_byp = '0;
    pulse_start(1'b0);
    send_bits(c_good, 1'b0);
    check_buses("postrst", 12'hB6D, 4'hF, 4'h0, 1'b0);

    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1);
  end

endmodule

`default_nettype wire

// File: doc/carry_cfg_loader.md
# carry_cfg_loader

Serial configuration loader that programs the carry-chain control fields of a column of `N_SLICES` logic slices in the emulator fabric. It accepts a bit-serial configuration frame over a valid/ready handshake and shifts the bits into a shadow register. It checks frame parity, then atomically commits the shadow contents to the registered select buses that drive each slice's `CY0_MUX_SEL`, `CYO_MUX_SEL` and `bypass` inputs. A bad frame leaves the active configuration untouched.

## Interface
Parameters:
- `N_SLICES`, 4, number of carry-chain slices configured by one frame.

Ports:
- `clk` in 1: single clock; all logic is rising-edge.
- `reset` in 1: synchronous, active-high.
- `cfg_start` in 1: one-cycle pulse that begins a frame.
- `cfg_valid` in 1: `cfg_data` is valid this cycle.
- `cfg_data` in 1: serial configuration bit.
- `cfg_ready` out 1: loader accepts a bit this cycle.
- `cy0_sel_bus` out 3*N_SLICES: slice i's `CY0_MUX_SEL` is bits [3i+2:3i].
- `cyo_sel_bus` out N_SLICES: slice i's `CYO_MUX_SEL` is bit i.
- `bypass_bus` out N_SLICES: slice i's `bypass` is bit i.
- `busy` out 1: a frame is in progress (any state other than IDLE).
- `cfg_done` out 1: one-cycle pulse when a good frame commits.
- `cfg_err` out 1: sticky parity error; cleared by the next accepted `cfg_start` or by `reset`.

## Operation
- **Frame format:** 5*N_SLICES data bits followed by 1 parity bit.
  - Data is sent slice 0 first.
  - Within a slice, bits are LSB-first: CY0[0], CY0[1], CY0[2], CYO, bypass.
- **Parity rule:** the XOR of all 5N+1 bits must be 0 (even parity).
- **Beat acceptance:** a bit is accepted when `cfg_valid && cfg_ready`. While `cfg_valid` is low, state holds and nothing is accepted.
- **State machine:**
  - IDLE: `cfg_ready`=0. On `cfg_start`: clear the bit counter, the shadow register, the running parity and `cfg_err`, then go to SHIFT.
  - SHIFT: `cfg_ready`=1. Each accepted bit is written to the shadow at the bit index given by the counter, XORed into the running parity, and the counter increments. After the beat where the counter equals 5N-1, go to CHECK.
  - CHECK: `cfg_ready`=1. On the accepted parity bit: if the final parity is 0, go to COMMIT; otherwise set `cfg_err` and go to IDLE.
  - COMMIT: copy shadow to the output buses, pulse `cfg_done`, go to IDLE. `cfg_ready`=0.
- **`cfg_start` during SHIFT or CHECK:** abort the current frame and restart it (same clears as from IDLE). Any bit presented that cycle is ignored. The active buses are unchanged.
- **`cfg_start` during COMMIT:** ignored.
- **Counter:** width is $clog2(5*N_SLICES+1). It never wraps, because the transition to CHECK bounds it.
- **Reset values:** all output buses 0, `cfg_ready` 0, `busy` 0, `cfg_done` 0, `cfg_err` 0. State is IDLE; shadow, counter and parity are all cleared.
- **Reset mid-frame:** the frame is discarded and the outputs return to their reset values.

## Timing
- `cfg_start` is sampled at cycle T. `busy` and `cfg_ready` are high from T+1.
- Minimum frame time: 5N+1 accepted beats, then one COMMIT cycle.
- **Good-frame latency:** with the parity bit accepted at cycle P, the output buses take their new values and `cfg_done`=1 in cycle P+1. In cycle P+2 the loader is back in IDLE and `busy`=0.
- **Bad-frame latency:** `cfg_err`=1 and `busy`=0 from P+1. The buses are unchanged.
- All outputs are registered. The output buses change only in the COMMIT cycle or on `reset`; slices never see a partial configuration.
- The earliest back-to-back `cfg_start` is accepted at P+2.

## Structure
- **Shared package `carry_cfg_pkg`:**
  - CFG_BITS_PER_SLICE = 5.
  - Field offsets CY0_LSB = 0, CYO_BIT = 3, BYP_BIT = 4.
  - State encoding for IDLE, SHIFT, CHECK, COMMIT.
- **Sub-module `carry_cfg_shadow`:** the indexed-write shadow register with its clear input, parameterised by total bit count.
- **Top level:** the FSM, counter, parity, and the active output registers.

## Test plan
The bench runs with N_SLICES=4, giving 20 data bits plus parity.
- **Good frame:** reset, then a frame with every slice set to CY0=101, CYO=1, bypass=0 (slice bits 1,0,1,1,0), parity bit 0. Expect `cy0_sel_bus`=12'hB6D, `cyo_sel_bus`=4'hF, `bypass_bus`=4'h0, and `cfg_done` pulsing exactly one cycle after the parity beat.
- **Bad parity:** after the good frame, send a frame of all ones with parity bit 1 (21 ones, odd). Expect `cfg_err`=1, buses unchanged at 12'hB6D/4'hF/4'h0, no `cfg_done`.
- **Stalls:** send the good frame with random `cfg_valid` gaps of 0–5 cycles. Expect the identical result as the unstalled frame, and no bit accepted while `cfg_valid`=0.
- **Abort:** pulse `cfg_start` after 7 beats, then send a full frame with only slice 3 bypass=1 (parity bit 1). Expect `bypass_bus`=4'h8, all other buses 0, and `cfg_err` cleared.
- **Reset mid-frame:** assert `reset` after 12 beats. Expect all outputs at their reset values next cycle, and the next full frame to load normally.
